// File: rtl/lsf_multich_input_sequencer.sv
// Purpose   : LSF engine input stage. Buffers ROIs and NUM_CH hit channels, then emits
//             one event at a time as ROI, a round-robin merge of hits over a window, and EOF.
// Latency   : ROI write to roi_vld_o is 2 cycles; hit write to hit_vld_o is 2 cycles (in HITS, FIFO empty).
// Backpress.: roi_vld_o/hit_vld_o hold with stable data until the matching rdy; a full FIFO drops the write.
//
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   hit_i / hit_we_i         NUM_CH packed hit words (channel c at [c*HIT_W +: HIT_W]) and write strobes
//   hit_af_o                 per-channel almost-full (level >= HIT_DEPTH-4)
//   roi_i / roi_we_i         ROI word and write strobe
//   roi_af_o                 ROI almost-full (level >= ROI_DEPTH-2)
//   accum_count_i            hit window length in cycles, sampled when the ROI is accepted
//   roi_o/roi_vld_o/roi_rdy_i       ROI output handshake
//   hit_o/hit_vld_o/hit_rdy_i       merged hit output handshake, hit_ch_o = source channel
//   eof_o                    one-cycle end-of-event pulse
//   busy_o                   sequencer not idle
//   ovf_o                    sticky overflow per hit channel, bit NUM_CH = ROI FIFO
//   evt_cnt_o, drop_cnt_o    only with LSF_SEQ_STATS_EN: event count and dropped-write count (wrap at 2^16)
//
// Optional build macro: LSF_SEQ_STATS_EN

// Generic FIFO: register-array storage, head word read straight from the array.
// Latency: write visible at the head the cycle after the write.
// Backpressure: a write while full (as sampled that cycle) is dropped and flagged on drop.
module lsf_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_dat,
  input  logic             rd_en,
  output logic [W-1:0]     rd_dat,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full   = (level == LVL_W'(DEPTH));
  assign empty  = (level == '0);
  // Full is judged before any same-cycle read, so a pop never rescues a write.
  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  assign drop   = wr_en && full;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

module lsf_multich_input_sequencer #(
  parameter int NUM_CH    = 2,
  parameter int HIT_W     = 64,
  parameter int ROI_W     = 64,
  parameter int HIT_DEPTH = 32,
  parameter int ROI_DEPTH = 8,
  parameter int CNT_W     = 10,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*HIT_W-1:0] hit_i,
  input  logic [NUM_CH-1:0]       hit_we_i,
  output logic [NUM_CH-1:0]       hit_af_o,
  input  logic [ROI_W-1:0]        roi_i,
  input  logic                    roi_we_i,
  output logic                    roi_af_o,
  input  logic [CNT_W-1:0]        accum_count_i,
  output logic [ROI_W-1:0]        roi_o,
  output logic                    roi_vld_o,
  input  logic                    roi_rdy_i,
  output logic [HIT_W-1:0]        hit_o,
  output logic                    hit_vld_o,
  input  logic                    hit_rdy_i,
  output logic [CH_W-1:0]         hit_ch_o,
  output logic                    eof_o,
  output logic                    busy_o,
`ifdef LSF_SEQ_STATS_EN
  output logic [15:0]             evt_cnt_o,
  output logic [15:0]             drop_cnt_o,
`endif
  output logic [NUM_CH:0]         ovf_o
);
  localparam int HLVL_W = $clog2(HIT_DEPTH) + 1;
  localparam int RLVL_W = $clog2(ROI_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROI  = 2'd1;
  localparam logic [1:0] ST_HITS = 2'd2;
  localparam logic [1:0] ST_EOF  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] win;
  logic [CH_W-1:0]  rr_ptr;

  logic [HIT_W-1:0]  hit_head [NUM_CH];
  logic [HLVL_W-1:0] hit_lvl  [NUM_CH];
  logic [NUM_CH-1:0] hit_empty;
  logic [NUM_CH-1:0] hit_full;
  logic [NUM_CH-1:0] hit_drop;
  logic [NUM_CH-1:0] hit_pop;

  logic [ROI_W-1:0]  roi_head;
  logic [RLVL_W-1:0] roi_lvl;
  logic              roi_empty;
  logic              roi_full;
  logic              roi_drop;
  logic              roi_pop;

  logic              take;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W:0]     cand;
  logic              do_grant;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lsf_seq_fifo #(.W(HIT_W), .DEPTH(HIT_DEPTH), .LVL_W(HLVL_W)) u_hit_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr_en  (hit_we_i[c]),
      .wr_dat (hit_i[c*HIT_W +: HIT_W]),
      .rd_en  (hit_pop[c]),
      .rd_dat (hit_head[c]),
      .empty  (hit_empty[c]),
      .full   (hit_full[c]),
      .level  (hit_lvl[c]),
      .drop   (hit_drop[c])
    );
    assign hit_af_o[c] = (hit_lvl[c] >= HLVL_W'(HIT_DEPTH - 4));
    assign hit_pop[c]  = do_grant && (gnt_idx == CH_W'(c));
  end

  lsf_seq_fifo #(.W(ROI_W), .DEPTH(ROI_DEPTH), .LVL_W(RLVL_W)) u_roi_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (roi_we_i),
    .wr_dat (roi_i),
    .rd_en  (roi_pop),
    .rd_dat (roi_head),
    .empty  (roi_empty),
    .full   (roi_full),
    .level  (roi_lvl),
    .drop   (roi_drop)
  );
  assign roi_af_o = (roi_lvl >= RLVL_W'(ROI_DEPTH - 2));
  assign roi_pop  = (state == ST_IDLE) && !roi_empty;

  // Output register can take a new hit when empty or being drained this cycle.
  assign take = !hit_vld_o || hit_rdy_i;

  // Round-robin: first non-empty channel strictly after rr_ptr, wrapping; rr_ptr
  // itself is visited last. cand needs one extra bit to hold rr_ptr+NUM_CH before wrap.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (!gnt_vld && !hit_empty[cand[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[CH_W-1:0];
      end
    end
  end

  assign do_grant = (state == ST_HITS) && (win != '0) && take && gnt_vld;

  assign eof_o  = (state == ST_EOF);
  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      win       <= '0;
      rr_ptr    <= CH_W'(NUM_CH - 1);
      roi_o     <= '0;
      roi_vld_o <= 1'b0;
      hit_o     <= '0;
      hit_vld_o <= 1'b0;
      hit_ch_o  <= '0;
      ovf_o     <= '0;
    end else begin
      ovf_o <= ovf_o | {roi_drop, hit_drop};
      case (state)
        ST_IDLE: begin
          if (!roi_empty) begin
            roi_o     <= roi_head;
            roi_vld_o <= 1'b1;
            state     <= ST_ROI;
          end
        end
        ST_ROI: begin
          if (roi_vld_o && roi_rdy_i) begin
            roi_vld_o <= 1'b0;
            win       <= accum_count_i;
            state     <= (accum_count_i == '0) ? ST_EOF : ST_HITS;
          end
        end
        ST_HITS: begin
          // The window is wall-clock: it runs down even while the engine stalls.
          if (win != '0) win <= win - 1'b1;
          if (do_grant) begin
            hit_o     <= hit_head[gnt_idx];
            hit_ch_o  <= gnt_idx;
            hit_vld_o <= 1'b1;
            rr_ptr    <= gnt_idx;
          end else if (hit_rdy_i) begin
            hit_vld_o <= 1'b0;
          end
          // Window closed: leave only once the last hit has gone.
          if ((win == '0) && take) state <= ST_EOF;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LSF_SEQ_STATS_EN
  logic [15:0] drop_sum;

  always_comb begin
    drop_sum = {15'd0, roi_drop};
    for (int c = 0; c < NUM_CH; c++) drop_sum = drop_sum + {15'd0, hit_drop[c]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      evt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      evt_cnt_o  <= evt_cnt_o + {15'd0, eof_o};
      drop_cnt_o <= drop_cnt_o + drop_sum;
    end
  end
`endif
endmodule

// File: tb/tb_lsf_multich_input_sequencer.sv
module tb_lsf_multich_input_sequencer;
  localparam int NUM_CH    = 2;
  localparam int HIT_W     = 16;
  localparam int ROI_W     = 16;
  localparam int HIT_DEPTH = 32;
  localparam int ROI_DEPTH = 8;
  localparam int CNT_W     = 10;
  localparam int CH_W      = 1;

  localparam logic [1:0] K_ROI = 2'd0;
  localparam logic [1:0] K_HIT = 2'd1;
  localparam logic [1:0] K_EOF = 2'd2;

  typedef struct {
    logic [1:0]      kind;
    logic [15:0]     dat;
    logic [CH_W-1:0] ch;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH*HIT_W-1:0] hit_i = '0;
  logic [NUM_CH-1:0]       hit_we_i = '0;
  logic [NUM_CH-1:0]       hit_af_o;
  logic [ROI_W-1:0]        roi_i = '0;
  logic                    roi_we_i = 1'b0;
  logic                    roi_af_o;
  logic [CNT_W-1:0]        accum_count_i = '0;
  logic [ROI_W-1:0]        roi_o;
  logic                    roi_vld_o;
  logic                    roi_rdy_i = 1'b1;
  logic [HIT_W-1:0]        hit_o;
  logic                    hit_vld_o;
  logic                    hit_rdy_i = 1'b1;
  logic [CH_W-1:0]         hit_ch_o;
  logic                    eof_o;
  logic                    busy_o;
  logic [NUM_CH:0]         ovf_o;
`ifdef LSF_SEQ_STATS_EN
  logic [15:0]             evt_cnt_o;
  logic [15:0]             drop_cnt_o;
`endif

  lsf_multich_input_sequencer #(
    .NUM_CH(NUM_CH), .HIT_W(HIT_W), .ROI_W(ROI_W),
    .HIT_DEPTH(HIT_DEPTH), .ROI_DEPTH(ROI_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .hit_i         (hit_i),
    .hit_we_i      (hit_we_i),
    .hit_af_o      (hit_af_o),
    .roi_i         (roi_i),
    .roi_we_i      (roi_we_i),
    .roi_af_o      (roi_af_o),
    .accum_count_i (accum_count_i),
    .roi_o         (roi_o),
    .roi_vld_o     (roi_vld_o),
    .roi_rdy_i     (roi_rdy_i),
    .hit_o         (hit_o),
    .hit_vld_o     (hit_vld_o),
    .hit_rdy_i     (hit_rdy_i),
    .hit_ch_o      (hit_ch_o),
    .eof_o         (eof_o),
    .busy_o        (busy_o),
`ifdef LSF_SEQ_STATS_EN
    .evt_cnt_o     (evt_cnt_o),
    .drop_cnt_o    (drop_cnt_o),
`endif
    .ovf_o         (ovf_o)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] d, input logic [CH_W-1:0] c);
    item_t it;
    it.kind = k;
    it.dat  = d;
    it.ch   = c;
    exp_q.push_back(it);
  endtask

  task automatic wr_hits(input logic [1:0] we, input logic [15:0] d0, input logic [15:0] d1);
    hit_i    = {d1, d0};
    hit_we_i = we;
    tick(1);
    hit_we_i = '0;
  endtask

  task automatic wr_roi(input logic [15:0] d, input logic [CNT_W-1:0] acc);
    accum_count_i = acc;
    roi_i         = d;
    roi_we_i      = 1'b1;
    tick(1);
    roi_we_i      = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy_o) begin
      errors++;
      $display("FAIL %s: timeout with %0d items left busy=%0b, want 0 left and idle",
               name, exp_q.size(), busy_o);
      exp_q.delete();
    end
  endtask

  // Monitor: every transfer or EOF pulse is matched in order against the scoreboard.
  task automatic observe(input logic [1:0] k, input logic [15:0] d, input logic [CH_W-1:0] c);
    item_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL stream: got kind=%0d dat=%0h ch=%0d, want nothing", k, d, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.dat !== d || e.ch !== c) begin
        errors++;
        $display("FAIL stream: got kind=%0d dat=%0h ch=%0d, want kind=%0d dat=%0h ch=%0d",
                 k, d, c, e.kind, e.dat, e.ch);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (roi_vld_o && roi_rdy_i) observe(K_ROI, roi_o, 1'b0);
      if (hit_vld_o && hit_rdy_i) observe(K_HIT, hit_o, hit_ch_o);
      if (eof_o)                  observe(K_EOF, 16'h0, 1'b0);
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_roi_vld", roi_vld_o, 0);
    check("rst_hit_vld", hit_vld_o, 0);
    check("rst_eof", eof_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_af", {hit_af_o, roi_af_o}, 0);

    // 1: ch0 A,B and ch1 C merged round-robin starting at ch0.
    wr_hits(2'b01, 16'h00A1, 16'h0);
    wr_hits(2'b11, 16'h00B2, 16'h00C3);
    push(K_ROI, 16'hA001, 0);
    push(K_HIT, 16'h00A1, 0);
    push(K_HIT, 16'h00C3, 1);
    push(K_HIT, 16'h00B2, 0);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA001, 10'd20);
    check("roi_lat_t1", roi_vld_o, 0);
    tick(1);
    check("roi_lat_t2", roi_vld_o, 1);
    wait_drain("t1_drain", 100);
    check("t1_busy_end", busy_o, 0);

    // 1b: hit latency while in HITS with empty FIFO.
    push(K_ROI, 16'hA002, 0);
    push(K_HIT, 16'h00D4, 1);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA002, 10'd30);
    tick(2);
    check("t1b_busy", busy_o, 1);
    wr_hits(2'b10, 16'h0, 16'h00D4);
    check("hit_lat_t1", hit_vld_o, 0);
    tick(1);
    check("hit_lat_t2", {hit_vld_o, hit_o}, {1'b1, 16'h00D4});
    wait_drain("t1b_drain", 100);

    // 2: zero window, hits stay queued for the following event.
    wr_hits(2'b11, 16'h00E5, 16'h00F6);
    push(K_ROI, 16'hA003, 0);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA003, 10'd0);
    tick(1);
    check("t2_roi_vld", roi_vld_o, 1);
    tick(1);
    check("t2_eof", {eof_o, hit_vld_o}, {1'b1, 1'b0});
    wait_drain("t2_drain", 50);
    push(K_ROI, 16'hA004, 0);
    push(K_HIT, 16'h00E5, 0);
    push(K_HIT, 16'h00F6, 1);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA004, 10'd20);
    wait_drain("t2b_drain", 100);

    // 3: stalled engine, window 4: one hit held, no grants after the window.
    wr_hits(2'b11, 16'h0017, 16'h0019);
    wr_hits(2'b01, 16'h0018, 16'h0);
    hit_rdy_i = 1'b0;
    push(K_ROI, 16'hA005, 0);
    push(K_HIT, 16'h0017, 0);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA005, 10'd4);
    tick(12);
    check("t3_hold", {hit_vld_o, hit_ch_o, hit_o}, {1'b1, 1'b0, 16'h0017});
    check("t3_busy_no_eof", {busy_o, eof_o}, {1'b1, 1'b0});
    hit_rdy_i = 1'b1;
    wait_drain("t3_drain", 50);
    push(K_ROI, 16'hA006, 0);
    push(K_HIT, 16'h0019, 1);
    push(K_HIT, 16'h0018, 0);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA006, 10'd10);
    wait_drain("t3b_drain", 50);

    // 4: fill ch1 and overflow it with a 33rd write.
    for (int i = 0; i < 33; i++) begin
      hit_i    = {16'h0100 + 16'(i), 16'h0};
      hit_we_i = 2'b10;
      tick(1);
      if (i == 26) check("af_at_27", hit_af_o[1], 0);
      if (i == 27) check("af_at_28", hit_af_o[1], 1);
      if (i == 31) check("ovf_before_drop", ovf_o, 0);
    end
    hit_we_i = '0;
    check("ovf_after_drop", ovf_o, 3'b010);
    check("af_ch0", hit_af_o[0], 0);
    push(K_ROI, 16'hA007, 0);
    for (int i = 0; i < 32; i++) push(K_HIT, 16'h0100 + 16'(i), 1);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA007, 10'd40);
    wait_drain("t4_drain", 200);

    // 5: reset while a hit is pending.
    wr_hits(2'b01, 16'h0021, 16'h0);
    wr_hits(2'b01, 16'h0022, 16'h0);
    hit_rdy_i = 1'b0;
    push(K_ROI, 16'hA008, 0);
    wr_roi(16'hA008, 10'd50);
    tick(5);
    check("t5_pending", hit_vld_o, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_after_rst", {hit_vld_o, roi_vld_o, busy_o, eof_o}, 0);
    check("t5_ovf_clr", ovf_o, 0);
    check("t5_q_consumed", exp_q.size(), 0);
    hit_rdy_i = 1'b1;
    push(K_ROI, 16'hA009, 0);
    push(K_EOF, 16'h0, 0);
    wr_roi(16'hA009, 10'd5);
    wait_drain("t5_drain", 50);

`ifdef LSF_SEQ_STATS_EN
    // 6: statistics counters.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    for (int e = 0; e < 3; e++) begin
      push(K_ROI, 16'hB000 + 16'(e), 0);
      push(K_EOF, 16'h0, 0);
      wr_roi(16'hB000 + 16'(e), 10'd0);
      wait_drain("t6_evt_drain", 50);
    end
    for (int i = 0; i < 32; i++) wr_hits(2'b11, 16'(i), 16'(i));
    check("t6_drop_before", drop_cnt_o, 0);
    wr_hits(2'b11, 16'h00FF, 16'h00FF);
    check("t6_evt_cnt", evt_cnt_o, 3);
    check("t6_drop_cnt", drop_cnt_o, 2);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
